// File: rtl/pet_prg_injector_if.sv
// Download-stream and RAM-DMA signal bundle for pet_prg_injector.
// master = injector side, slave = host/RAM side.
interface pet_prg_injector_if;
    logic        dl_active;
    logic        dl_valid;
    logic [7:0]  dl_data;
    logic        dl_ready;
    logic [14:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;

    modport master (
        input  dl_active, dl_valid, dl_data,
        output dl_ready, dma_addr, dma_din, dma_we
    );

    modport slave (
        output dl_active, dl_valid, dl_data,
        input  dl_ready, dma_addr, dma_din, dma_we
    );
endinterface

// File: rtl/pet_prg_injector.sv
// Loads a .PRG byte stream into PET RAM through the DMA port, then
// patches the BASIC VARTAB/ARYTAB/STREND pointers to the end address.
module pet_prg_injector #(
    parameter bit         PATCH_EN = 1'b1,
    parameter logic [7:0] PTR_BASE = 8'h2A
) (
    input  logic               clk,
    input  logic               reset,
    pet_prg_injector_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [15:0]        load_start,
    output logic [15:0]        load_end
);

    typedef enum logic [2:0] {
        IDLE, HDR_LO, HDR_HI, DATA, PATCH, DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        act_q;
    logic        rise;
    logic        rx_state;
    logic        accept;
    logic [15:0] cur_addr;
    logic        wr_pend;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  patch_cnt;

    // Follows the pin through reset too, so a level held across reset
    // is never mistaken for a start edge.
    always_ff @(posedge clk) begin
        act_q <= bus.dl_active;
    end

    assign rise     = bus.dl_active & ~act_q;
    assign rx_state = (state == HDR_LO) || (state == HDR_HI) ||
                      (state == DATA);
    assign accept   = rx_state & bus.dl_active & bus.dl_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.dl_ready = rx_state;
        busy         = (state != IDLE);
        done         = (state == DONE);
        bus.dma_we   = wr_pend;
        bus.dma_addr = wr_addr;
        bus.dma_din  = wr_data;
        unique case (state)
            IDLE: begin
                if (rise) state_nxt = HDR_LO;
            end
            HDR_LO: begin
                if (!bus.dl_active) state_nxt = DONE;
                else if (accept)    state_nxt = HDR_HI;
            end
            HDR_HI: begin
                if (!bus.dl_active) state_nxt = DONE;
                else if (accept)    state_nxt = DATA;
            end
            DATA: begin
                if (!bus.dl_active) begin
                    state_nxt = (PATCH_EN && !error) ? PATCH : DONE;
                end
            end
            PATCH: begin
                bus.dma_we   = 1'b1;
                bus.dma_addr = {7'd0, PTR_BASE} + {12'd0, patch_cnt};
                bus.dma_din  = patch_cnt[0] ? load_end[15:8]
                                            : load_end[7:0];
                if (patch_cnt == 3'd5) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error      <= 1'b0;
            load_start <= 16'd0;
            load_end   <= 16'd0;
            cur_addr   <= 16'd0;
            wr_pend    <= 1'b0;
            wr_addr    <= 15'd0;
            wr_data    <= 8'd0;
            patch_cnt  <= 3'd0;
        end else begin
            wr_pend <= 1'b0;
            unique case (state)
                IDLE: begin
                    patch_cnt <= 3'd0;
                    if (rise) error <= 1'b0;
                end
                HDR_LO: begin
                    if (!bus.dl_active) begin
                        error <= 1'b1;
                    end else if (accept) begin
                        load_start[7:0] <= bus.dl_data;
                    end
                end
                HDR_HI: begin
                    if (!bus.dl_active) begin
                        error <= 1'b1;
                    end else if (accept) begin
                        load_start[15:8] <= bus.dl_data;
                        cur_addr <= {bus.dl_data, load_start[7:0]};
                        if (bus.dl_data[7]) error <= 1'b1;
                    end
                end
                DATA: begin
                    if (!bus.dl_active) begin
                        load_end <= cur_addr;
                    end else if (accept) begin
                        // Past the 32KB window: swallow, flag, hold address.
                        if (cur_addr[15]) begin
                            error <= 1'b1;
                        end else begin
                            wr_pend  <= 1'b1;
                            wr_addr  <= cur_addr[14:0];
                            wr_data  <= bus.dl_data;
                            cur_addr <= cur_addr + 16'd1;
                        end
                    end
                end
                PATCH: begin
                    patch_cnt <= patch_cnt + 3'd1;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pet_prg_injector.sv
// Bench for pet_prg_injector: directed and random .PRG loads checked
// against a byte-level model of the expected RAM writes.
module tb_pet_prg_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] load_start;
    logic [15:0] load_end;

    pet_prg_injector_if bus();

    pet_prg_injector dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .load_start (load_start),
        .load_end   (load_end)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [22:0] wr_q[$];
    int          wr_cyc[$];
    int          done_cnt = 0;
    int          bad_we = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.dma_we) begin
            wr_q.push_back({bus.dma_addr, bus.dma_din});
            wr_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
        if (bus.dma_we && (!busy || done)) bad_we++;
    end

    logic [22:0] exp_q[$];
    bit          exp_err;
    logic [15:0] exp_start;
    logic [15:0] exp_end;
    bit          exp_end_valid;

    // Expected RAM writes from the PRG rules: header, payload, pointers.
    task automatic model(input logic [7:0] s[$]);
        logic [15:0] a;
        exp_q = {};
        exp_err = 1'b0;
        exp_end_valid = 1'b0;
        if (s.size() < 2) begin
            exp_err = 1'b1;
            return;
        end
        exp_start = {s[1], s[0]};
        a = exp_start;
        exp_err = (a >= 16'h8000);
        for (int i = 2; i < s.size(); i++) begin
            if (a < 16'h8000) begin
                exp_q.push_back({a[14:0], s[i]});
                a = a + 16'd1;
            end else begin
                exp_err = 1'b1;
            end
        end
        exp_end = a;
        exp_end_valid = (exp_start < 16'h8000);
        if (!exp_err) begin
            for (int k = 0; k < 6; k++) begin
                exp_q.push_back({15'(16'h2A + k),
                                 (k % 2 == 1) ? a[15:8] : a[7:0]});
            end
        end
    endtask

    task automatic feed(input logic [7:0] s[$], input int gap_pct,
                        output bit to);
        bit got;
        int n;
        to = 1'b0;
        for (int i = 0; i < s.size(); i++) begin
            got = 1'b0;
            n = 0;
            while (!got && !to) begin
                @(negedge clk);
                if ($urandom_range(99) < gap_pct) begin
                    bus.dl_valid = 1'b0;
                end else begin
                    bus.dl_valid = 1'b1;
                    bus.dl_data  = s[i];
                    #1;
                    got = bus.dl_ready;
                end
                n++;
                if (n > 40) to = 1'b1;
            end
            if (to) break;
        end
    endtask

    task automatic load_and_check(input string name,
                                  input logic [7:0] s[$],
                                  input int gap_pct,
                                  input bit dirty_tail,
                                  input bit chk_b2b);
        bit to;
        int n;
        int m;
        model(s);
        wr_q = {};
        wr_cyc = {};
        done_cnt = 0;
        bad_we = 0;
        @(negedge clk);
        bus.dl_active = 1'b1;
        bus.dl_valid  = 1'b0;
        feed(s, gap_pct, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL %s feed_timeout: dl_ready never rose", name);
        end
        @(negedge clk);
        bus.dl_active = 1'b0;
        bus.dl_valid  = dirty_tail;
        bus.dl_data   = 8'($urandom);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        bus.dl_valid = 1'b0;
        repeat (3) @(negedge clk);

        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_after: got %b want 0", name, busy);
        end
        vectors++;
        if (error !== exp_err) begin
            miscompares++;
            $display("FAIL %s error: got %b want %b", name, error, exp_err);
        end
        vectors++;
        if (bad_we !== 0) begin
            miscompares++;
            $display("FAIL %s we_idle_done: got %0d want 0", name, bad_we);
        end
        vectors++;
        if (wr_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d want %0d",
                     name, wr_q.size(), exp_q.size());
        end
        m = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            vectors++;
            if (wr_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s write[%0d]: got %h=%h want %h=%h",
                         name, i, wr_q[i][22:8], wr_q[i][7:0],
                         exp_q[i][22:8], exp_q[i][7:0]);
            end
        end
        if (s.size() >= 2) begin
            vectors++;
            if (load_start !== exp_start) begin
                miscompares++;
                $display("FAIL %s load_start: got %h want %h",
                         name, load_start, exp_start);
            end
        end
        if (exp_end_valid) begin
            vectors++;
            if (load_end !== exp_end) begin
                miscompares++;
                $display("FAIL %s load_end: got %h want %h",
                         name, load_end, exp_end);
            end
        end
        if (chk_b2b) begin
            for (int i = 1; i < m && i < s.size() - 2; i++) begin
                vectors++;
                if (wr_cyc[i] !== wr_cyc[i-1] + 1) begin
                    miscompares++;
                    $display("FAIL %s b2b_cycle[%0d]: got %0d want %0d",
                             name, i, wr_cyc[i], wr_cyc[i-1] + 1);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.dl_active = 1'b0;
        bus.dl_valid  = 1'b0;
        bus.dl_data   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, error, bus.dma_we, bus.dl_ready} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, done, error, bus.dma_we, bus.dl_ready});
        end
        vectors++;
        if (load_start !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_load_start: got %h want 0000", load_start);
        end
        vectors++;
        if (load_end !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_load_end: got %h want 0000", load_end);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_load();
        logic [7:0] s[$];
        s = {8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
        load_and_check("t1_basic", s, 0, 1'b0, 1'b0);
    endtask

    task automatic test_header_high();
        logic [7:0] s[$];
        s = {8'h00, 8'h80, 8'h11, 8'h22, 8'h33};
        load_and_check("t2_hdr_8000", s, 0, 1'b0, 1'b0);
    endtask

    task automatic test_top_overflow();
        logic [7:0] s[$];
        s = {8'hFE, 8'h7F, 8'h01, 8'h02, 8'h03, 8'h04};
        load_and_check("t3_overflow", s, 0, 1'b1, 1'b0);
    endtask

    task automatic test_header_only();
        logic [7:0] s[$];
        s = {8'h01, 8'h04};
        load_and_check("t4_hdr_only", s, 0, 1'b1, 1'b0);
    endtask

    task automatic test_short_header();
        logic [7:0] s[$];
        s = {8'h01};
        load_and_check("t6_short", s, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$];
        s = {8'h00, 8'h20};
        for (int i = 0; i < 16; i++) s.push_back(8'($urandom));
        load_and_check("t6_b2b", s, 0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] s[$];
        bit to;
        s = {8'h00, 8'h10, 8'h11, 8'h22, 8'h33};
        @(negedge clk);
        bus.dl_active = 1'b1;
        bus.dl_valid  = 1'b0;
        feed(s[0:3], 0, to);
        @(negedge clk);
        bus.dl_valid = 1'b0;
        vectors++;
        if (to || bus.dma_we !== 1'b1) begin
            miscompares++;
            $display("FAIL t5_pending_we: got %b want 1 (timeout %b)",
                     bus.dma_we, to);
        end
        done_cnt = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.dma_we, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL t5_abort: got we/busy/done=%b want 000",
                     {bus.dma_we, busy, done});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done_cnt !== 0) begin
            miscompares++;
            $display("FAIL t5_level_start: got busy=%b done=%0d want 0/0",
                     busy, done_cnt);
        end
        bus.dl_active = 1'b0;
        @(negedge clk);
        s = {8'h00, 8'h03, 8'h5A, 8'hA5, 8'h3C};
        load_and_check("t5_restart", s, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] s[$];
        logic [15:0] a;
        int sel;
        for (int t = 0; t < 10; t++) begin
            sel = $urandom_range(3);
            if (sel < 2)       a = 16'h0400 + 16'($urandom_range(16'h3000));
            else if (sel == 2) a = 16'h7FF0 + 16'($urandom_range(15));
            else               a = 16'h8000 + 16'($urandom_range(255));
            s = {a[7:0], a[15:8]};
            for (int i = 0; i < int'($urandom_range(20)); i++) begin
                s.push_back(8'($urandom));
            end
            load_and_check($sformatf("rand%0d", t), s, 30,
                           1'($urandom), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_header_high();
        test_top_overflow();
        test_header_only();
        test_short_header();
        test_back_to_back();
        test_reset_mid_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench still running at time limit");
        $fatal(1, "watchdog");
    end

endmodule
